// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock through a narrow ripple slice.
// Wrap or unsigned-saturate result, valid/ready on both sides.
module chunked_adder #(
  parameter int WIDTH = 10,
  parameter int CHUNK = 5,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t state;
  state_t stateNext;

  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] resReg;
  logic [WIDTH-1:0] rawRes;
  logic [WIDTH-1:0] modeRes;
  logic [CHUNK:0]   slice;
  logic [IW-1:0]    idx;
  logic             carryReg;
  logic             subReg;
  logic             accept;
  logic             lastChunk;
  logic             rawOvf;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign lastChunk = (idx == IW'(NCH - 1));

  always_comb begin
    slice = {1'b0, opA[idx*CHUNK +: CHUNK]}
          + {1'b0, opB[idx*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, carryReg};
    rawRes = resReg;
    rawRes[idx*CHUNK +: CHUNK] = slice[CHUNK-1:0];
    // subtract runs as A + ~B + 1, so a missing carry means borrow
    rawOvf  = subReg ? !slice[CHUNK] : slice[CHUNK];
    modeRes = rawRes;
    if (MODE == 1 && rawOvf) begin
      modeRes = subReg ? '0 : '1;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (accept)    stateNext = ADD;
      ADD:     if (lastChunk) stateNext = DONE;
      DONE:    if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      opA       <= '0;
      opB       <= '0;
      resReg    <= '0;
      idx       <= '0;
      carryReg  <= 1'b0;
      subReg    <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) begin
        opA      <= a;
        opB      <= sub ? ~b : b;
        carryReg <= sub;
        subReg   <= sub;
        idx      <= '0;
      end
      if (state == ADD) begin
        resReg   <= rawRes;
        carryReg <= slice[CHUNK];
        idx      <= idx + 1'b1;
        if (lastChunk) begin
          sum       <= modeRes;
          carry_out <= slice[CHUNK];
          overflow  <= rawOvf;
        end
      end
    end
  end
endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench: wrap and saturate instances share stimulus;
// a scoreboard queue holds expected results per accepted operation.
module tb_chunked_adder;
  localparam int W = 10;

  typedef struct {
    logic [W-1:0] s0;
    logic [W-1:0] s1;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         inValid;
  logic         outReady;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         rdy0;
  logic         rdy1;
  logic         ov0;
  logic         ov1;
  logic [W-1:0] sum0;
  logic [W-1:0] sum1;
  logic         c0;
  logic         c1;
  logic         o0;
  logic         o1;

  exp_t q[$];
  int   checks;
  int   failures;
  time  acceptT;
  time  prevT;

  chunked_adder #(.WIDTH(10), .CHUNK(5), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(rdy0),
    .a(a), .b(b), .sub(sub), .out_valid(ov0), .out_ready(outReady),
    .sum(sum0), .carry_out(c0), .overflow(o0)
  );

  chunked_adder #(.WIDTH(10), .CHUNK(5), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(rdy1),
    .a(a), .b(b), .sub(sub), .out_valid(ov1), .out_ready(outReady),
    .sum(sum1), .carry_out(c1), .overflow(o1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic s);
    exp_t e;
    logic [W:0] raw;
    raw = s ? ({1'b0, x} - {1'b0, y} + 11'd1024)
            : ({1'b0, x} + {1'b0, y});
    e.s0 = raw[W-1:0];
    e.c  = raw[W];
    e.o  = s ? !raw[W] : raw[W];
    e.s1 = e.o ? (s ? '0 : '1) : raw[W-1:0];
    return e;
  endfunction

  task automatic startOp(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s);
    q.push_back(model(x, y, s));
    a = x;
    b = y;
    sub = s;
    inValid = 1'b1;
    chk("in_ready_before_accept", {31'd0, rdy0 & rdy1}, 32'd1);
    @(posedge clk);
    acceptT = $time;
    #1;
    inValid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic waitOut();
    int lat;
    lat = 0;
    while (!ov0 && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 2);
    chk("out_valid_mode1", {31'd0, ov1}, 32'd1);
  endtask

  task automatic checkOut(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    chk({tag, "_sum_wrap"}, {22'd0, sum0}, {22'd0, e.s0});
    chk({tag, "_sum_sat"}, {22'd0, sum1}, {22'd0, e.s1});
    chk({tag, "_carry"}, {30'd0, c1, c0}, {30'd0, e.c, e.c});
    chk({tag, "_ovf"}, {30'd0, o1, o0}, {30'd0, e.o, e.o});
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic s);
    startOp(x, y, s);
    waitOut();
    checkOut(tag);
    @(posedge clk);
    #1;
    chk({tag, "_drained"}, {31'd0, ov0}, 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    inValid = 1'b0;
    outReady = 1'b1;
    a = '0;
    b = '0;
    sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, ov0 | ov1}, 32'd0);
    chk("reset_sum", {12'd0, sum1, sum0}, 32'd0);
    chk("reset_flags", {28'd0, c0, c1, o0, o1}, 32'd0);
    chk("reset_in_ready", {31'd0, rdy0 | rdy1}, 32'd0);
    rst = 1'b0;
    #1;

    runOp("add17_25", 10'd17, 10'd25, 1'b0);
    runOp("add1023_1", 10'd1023, 10'd1, 1'b0);
    runOp("sub5_9", 10'd5, 10'd9, 1'b1);
    runOp("sub9_5", 10'd9, 10'd5, 1'b1);
    runOp("add31_1", 10'd31, 10'd1, 1'b0);
    runOp("add992_32", 10'd992, 10'd32, 1'b0);
    runOp("zero", 10'd0, 10'd0, 1'b0);
    runOp("aminusa", 10'd700, 10'd700, 1'b1);
    runOp("sub0_1", 10'd0, 10'd1, 1'b1);

    outReady = 1'b0;
    startOp(10'd600, 10'd300, 1'b0);
    waitOut();
    checkOut("held");
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        a = 10'd1;
        b = 10'd1;
        sub = 1'b0;
        inValid = 1'b1;
      end
      chk("held_in_ready", {31'd0, rdy0 | rdy1}, 32'd0);
      @(posedge clk);
      #1;
      inValid = 1'b0;
      chk("held_valid", {31'd0, ov0 & ov1}, 32'd1);
      chk("held_sum", {22'd0, sum0}, 32'd900);
    end
    outReady = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", {31'd0, rdy0 & rdy1}, 32'd1);
    chk("release_valid", {31'd0, ov0 | ov1}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("pulsed_op_lost", {31'd0, ov0 | ov1}, 32'd0);

    startOp(10'd100, 10'd200, 1'b0);
    void'(q.pop_back());
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", {31'd0, ov0 | ov1}, 32'd0);
    chk("midrst_sum", {12'd0, sum1, sum0}, 32'd0);
    chk("midrst_in_ready", {31'd0, rdy0 | rdy1}, 32'd0);
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", {31'd0, rdy0 & rdy1}, 32'd1);
    runOp("add3_4", 10'd3, 10'd4, 1'b0);

    runOp("b2b_0", 10'd511, 10'd513, 1'b0);
    prevT = acceptT;
    runOp("b2b_1", 10'd250, 10'd260, 1'b1);
    chk("spacing_1", 32'((acceptT - prevT) / 10), 32'd4);
    prevT = acceptT;
    runOp("b2b_2", 10'd1000, 10'd23, 1'b0);
    chk("spacing_2", 32'((acceptT - prevT) / 10), 32'd4);
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
